// File: rtl/pc_unit.sv
// Program counter with trap/exception return and a circular return-address stack.
// All state is registered; only misaligned is derived combinationally from pc.
module pc_unit #(
    parameter int unsigned       WIDTH     = 16,
    parameter int unsigned       STEP      = 4,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter logic [WIDTH-1:0]  TRAP_VEC  = WIDTH'(16'h0010),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         trap,
    input  logic                         trap_ret,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         misaligned
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [PW-1:0]    top_q, top_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];

    logic [WIDTH-1:0] seq_pc;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;
    logic             stack_nonempty;

    assign seq_pc         = pc_q + STEP_W;
    assign stack_nonempty = (cnt_q != '0);

    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_replace = 1'b0;

        if (trap) begin
            epc_d = pc_q;
            pc_d  = TRAP_VEC;
        end else if (trap_ret) begin
            pc_d = epc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (stack_nonempty) begin
                pc_d = ras_q[top_q];
                // ret+call swaps the top in place so the depth is unchanged
                if (call && redirect) begin
                    do_replace = 1'b1;
                end else begin
                    do_pop = 1'b1;
                end
            end else begin
                pc_d    = redirect_target;
                do_push = call && redirect;
            end
        end else if (redirect) begin
            pc_d    = redirect_target;
            do_push = call;
        end else begin
            pc_d = seq_pc;
        end
    end

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        ras_d = ras_q;

        // Full push advances the pointer onto the oldest slot, overwriting it
        if (do_push) begin
            top_d        = top_q + 1'b1;
            ras_d[top_d] = seq_pc;
            if (cnt_q != DEPTH_C) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end else if (do_replace) begin
            ras_d[top_q] = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            top_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign pc         = pc_q;
    assign epc        = epc_q;
    assign ras_count  = cnt_q;
    assign ras_empty  = (cnt_q == '0);
    assign ras_full   = (cnt_q == DEPTH_C);
    assign misaligned = ((pc_q & (STEP_W - 1'b1)) != '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit at default parameters: a vector table applied one
// edge per entry, followed by hand-written asynchronous reset sequences.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        call;
    logic        ret;
    logic        trap;
    logic        trap_ret;
    logic [15:0] pc;
    logic [15:0] epc;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

    pc_unit #(
        .WIDTH     (16),
        .STEP      (4),
        .RESET_VEC (16'h0000),
        .TRAP_VEC  (16'h0010),
        .RAS_DEPTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .trap            (trap),
        .trap_ret        (trap_ret),
        .pc              (pc),
        .epc             (epc),
        .ras_count       (ras_count),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .misaligned      (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag vector order: {stall, redirect, call, ret, trap, trap_ret}
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] ST   = 6'b100000;
    localparam logic [5:0] RD   = 6'b010000;
    localparam logic [5:0] CA   = 6'b001000;
    localparam logic [5:0] RDC  = 6'b011000;
    localparam logic [5:0] RT   = 6'b000100;
    localparam logic [5:0] TP   = 6'b000010;
    localparam logic [5:0] TR   = 6'b000001;

    typedef struct {
        logic [5:0]  fl;
        logic [15:0] tgt;
        logic [15:0] exp_pc;
        logic [15:0] exp_epc;
        logic [2:0]  exp_cnt;
    } vec_t;

    localparam int NV = 40;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] fl, input logic [15:0] tgt);
        {stall, redirect, call, ret, trap, trap_ret} = fl;
        redirect_target = tgt;
    endtask

    initial begin
        vecs[0]  = '{IDLE,    16'h0000, 16'h0004, 16'h0000, 3'd0};
        vecs[1]  = '{IDLE,    16'h0000, 16'h0008, 16'h0000, 3'd0};
        vecs[2]  = '{IDLE,    16'h0000, 16'h000C, 16'h0000, 3'd0};
        vecs[3]  = '{RD,      16'h0100, 16'h0100, 16'h0000, 3'd0};
        vecs[4]  = '{RDC,     16'h0200, 16'h0200, 16'h0000, 3'd1};
        vecs[5]  = '{IDLE,    16'h0000, 16'h0204, 16'h0000, 3'd1};
        vecs[6]  = '{RT | RD, 16'h0555, 16'h0104, 16'h0000, 3'd0};
        vecs[7]  = '{RT,      16'h07F0, 16'h07F0, 16'h0000, 3'd0};
        vecs[8]  = '{RD,      16'h000C, 16'h000C, 16'h0000, 3'd0};
        vecs[9]  = '{RDC,     16'h001C, 16'h001C, 16'h0000, 3'd1};
        vecs[10] = '{RDC,     16'h002C, 16'h002C, 16'h0000, 3'd2};
        vecs[11] = '{RDC,     16'h003C, 16'h003C, 16'h0000, 3'd3};
        vecs[12] = '{RDC,     16'h004C, 16'h004C, 16'h0000, 3'd4};
        vecs[13] = '{RDC,     16'h0100, 16'h0100, 16'h0000, 3'd4};
        vecs[14] = '{RT,      16'h07F0, 16'h0050, 16'h0000, 3'd3};
        vecs[15] = '{RT,      16'h07F0, 16'h0040, 16'h0000, 3'd2};
        vecs[16] = '{RT,      16'h07F0, 16'h0030, 16'h0000, 3'd1};
        vecs[17] = '{RT,      16'h07F0, 16'h0020, 16'h0000, 3'd0};
        vecs[18] = '{RT,      16'h07F0, 16'h07F0, 16'h0000, 3'd0};
        vecs[19] = '{RD,      16'h0300, 16'h0300, 16'h0000, 3'd0};
        vecs[20] = '{ST | TP, 16'h0000, 16'h0010, 16'h0300, 3'd0};
        vecs[21] = '{IDLE,    16'h0000, 16'h0014, 16'h0300, 3'd0};
        vecs[22] = '{TP,      16'h0000, 16'h0010, 16'h0014, 3'd0};
        vecs[23] = '{TR | ST, 16'h0000, 16'h0014, 16'h0014, 3'd0};
        vecs[24] = '{TP | TR, 16'h0000, 16'h0010, 16'h0014, 3'd0};
        vecs[25] = '{TR,      16'h0000, 16'h0014, 16'h0014, 3'd0};
        vecs[26] = '{RD,      16'hFFFC, 16'hFFFC, 16'h0014, 3'd0};
        vecs[27] = '{IDLE,    16'h0000, 16'h0000, 16'h0014, 3'd0};
        vecs[28] = '{RDC,     16'h0400, 16'h0400, 16'h0014, 3'd1};
        vecs[29] = '{ST | RDC,16'h0800, 16'h0400, 16'h0014, 3'd1};
        vecs[30] = '{ST | RD, 16'h0800, 16'h0400, 16'h0014, 3'd1};
        vecs[31] = '{ST | RT, 16'h0800, 16'h0400, 16'h0014, 3'd1};
        vecs[32] = '{CA,      16'h0800, 16'h0404, 16'h0014, 3'd1};
        vecs[33] = '{RT | RDC,16'h0900, 16'h0004, 16'h0014, 3'd1};
        vecs[34] = '{RT,      16'h0900, 16'h0408, 16'h0014, 3'd0};
        vecs[35] = '{RT | RDC,16'h0900, 16'h0900, 16'h0014, 3'd1};
        vecs[36] = '{RT,      16'h0000, 16'h040C, 16'h0014, 3'd0};
        vecs[37] = '{RD,      16'h0002, 16'h0002, 16'h0014, 3'd0};
        vecs[38] = '{IDLE,    16'h0000, 16'h0006, 16'h0014, 3'd0};
        vecs[39] = '{RD,      16'h0008, 16'h0008, 16'h0014, 3'd0};

        reset = 1'b0;
        drive(IDLE, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", 32'(pc), 32'h0000);
        chk("reset_epc", 32'(epc), 32'h0000);
        chk("reset_cnt", 32'(ras_count), 32'd0);
        chk("reset_empty", 32'(ras_empty), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fl, vecs[i].tgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_epc", i), 32'(epc), 32'(vecs[i].exp_epc));
            chk($sformatf("v%0d_cnt", i), 32'(ras_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_empty", i), 32'(ras_empty), 32'(vecs[i].exp_cnt == 3'd0));
            chk($sformatf("v%0d_full", i), 32'(ras_full), 32'(vecs[i].exp_cnt == 3'd4));
            chk($sformatf("v%0d_mis", i), 32'(misaligned), 32'(vecs[i].exp_pc[1:0] != 2'b00));
        end

        // Build three RAS entries, then assert reset between edges with stall and trap pending
        drive(RDC, 16'h0100);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_async_cnt", 32'(ras_count), 32'd3);
        chk("pre_async_pc", 32'(pc), 32'h0100);
        drive(ST | TP, 16'h0000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc", 32'(pc), 32'h0000);
        chk("async_epc", 32'(epc), 32'h0000);
        chk("async_cnt", 32'(ras_count), 32'd0);
        chk("async_empty", 32'(ras_empty), 32'd1);

        drive(RDC, 16'h0200);
        repeat (2) @(posedge clk);
        #1;
        chk("held_rst_pc", 32'(pc), 32'h0000);
        chk("held_rst_cnt", 32'(ras_count), 32'd0);

        // First edge after release evaluates normally; empty-stack ret falls back to target
        drive(RT | RD, 16'h0660);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ret_pc", 32'(pc), 32'h0660);
        chk("post_rst_ret_cnt", 32'(ras_count), 32'd0);
        drive(IDLE, 16'h0000);
        @(posedge clk);
        #1;
        chk("post_rst_seq_pc", 32'(pc), 32'h0664);
        chk("post_rst_epc", 32'(epc), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
